// File: rtl/btn_cmd_gen_pkg.sv
// rtl/btn_cmd_gen_pkg.sv - shared state encoding, default parameters and clog2 for btn_cmd_gen
package btn_cmd_gen_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARM    = 2'd1;
  localparam logic [1:0] HELD   = 2'd2;
  localparam logic [1:0] DISARM = 2'd3;

  localparam int DEF_DEB_CYCLES    = 4;
  localparam int DEF_REPEAT_DELAY  = 8;
  localparam int DEF_REPEAT_PERIOD = 4;

  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_cmd_gen_debounce.sv
// rtl/btn_cmd_gen_debounce.sv - per-button synchroniser, debounce FSM and repeat events
// Optional auto-repeat is built only when BTN_AUTO_REPEAT_EN is defined.
module btn_debounce
  import btn_cmd_gen_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk_out,
  input  logic RESET,
  input  logic raw,
  output logic lvl,
  output logic evt
);

  localparam int CW = clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("btn_debounce: DEB_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic          sync1;
  logic          s;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          press;

  always_ff @(posedge clk_out) begin
    if (RESET) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
    end
  end

  // >= rather than == so that DEB_CYCLES=1 still leaves ARM/DISARM after one cycle
  always_ff @(posedge clk_out) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (s) begin
          state <= ARM;
          cnt   <= CW'(1);
        end
        ARM: if (!s) begin
          state <= IDLE;
          cnt   <= '0;
        end else if (cnt >= CNT_LAST) begin
          state <= HELD;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
        HELD: if (!s) begin
          state <= DISARM;
          cnt   <= CW'(1);
        end
        default: if (s) begin
          state <= HELD;
          cnt   <= '0;
        end else if (cnt >= CNT_LAST) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      endcase
    end
  end

  assign press = (state == ARM) && s && (cnt >= CNT_LAST);
  assign lvl   = state[1];

`ifdef BTN_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = clog2(RMAX + 1);

  logic [RW-1:0] rcnt;
  logic          rep_on;
  logic          rep;

  assign rep = (state == HELD) &&
               (rep_on ? (rcnt == RW'(REPEAT_PERIOD - 1)) : (rcnt == RW'(REPEAT_DELAY - 1)));

  // Counter only advances in HELD; DISARM freezes it so a bounce back to HELD resumes the cadence
  always_ff @(posedge clk_out) begin
    if (RESET || press || state == IDLE) begin
      rcnt   <= '0;
      rep_on <= 1'b0;
    end else if (state == HELD) begin
      if (rep) begin
        rcnt   <= '0;
        rep_on <= 1'b1;
      end else begin
        rcnt <= rcnt + RW'(1);
      end
    end
  end

  assign evt = press | rep;
`else
  assign evt = press;
`endif

endmodule

// File: rtl/btn_cmd_gen.sv
// rtl/btn_cmd_gen.sv - debounced UP/DN command pulse generator for the LED up/down counter
// Auto-repeat of held buttons is enabled by defining BTN_AUTO_REPEAT_EN.
module btn_cmd_gen
  import btn_cmd_gen_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk_out,
  input  logic RESET,
  input  logic BTN0_RAW,
  input  logic BTN1_RAW,
  output logic UP_PULSE,
  output logic DN_PULSE,
  output logic BTN0_LVL,
  output logic BTN1_LVL
);

  logic evt0;
  logic evt1;

  btn_debounce #(
    .DEB_CYCLES   (DEB_CYCLES),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_btn0 (
    .clk_out(clk_out),
    .RESET  (RESET),
    .raw    (BTN0_RAW),
    .lvl    (BTN0_LVL),
    .evt    (evt0)
  );

  btn_debounce #(
    .DEB_CYCLES   (DEB_CYCLES),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_btn1 (
    .clk_out(clk_out),
    .RESET  (RESET),
    .raw    (BTN1_RAW),
    .lvl    (BTN1_LVL),
    .evt    (evt1)
  );

  // BTN0 wins a same-cycle collision, as the counter does; the BTN1 event is dropped
  always_ff @(posedge clk_out) begin
    if (RESET) begin
      UP_PULSE <= 1'b0;
      DN_PULSE <= 1'b0;
    end else begin
      UP_PULSE <= evt0;
      DN_PULSE <= evt1 & ~evt0;
    end
  end

endmodule
